shift_reg_univ: RTL and testbench

Parametrised universal shift register: the successor to the fixed 4-bit D-flip-flop shifter. It supports hold, shift right, shift left and parallel load, and adds a counted burst-shift controller with a busy/done handshake. It sits between serial links and parallel datapaths in serialiser/deserialiser and bit-manipulation paths. An optional rotate feature can be compiled in.

---
 rtl/shreg_pkg.sv | 20 ++
 rtl/shreg_ctrl.sv | 89 ++++++++
 rtl/shift_reg_univ.sv | 92 +++++++++
 tb/tb_shift_reg_univ.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings, burst FSM states
// and a mode-classification helper.
package shreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shreg_ctrl.sv
// Burst-shift controller: IDLE/SHIFT/DONE FSM with the remaining-shift counter,
// producing the burst shift-enable, latched direction and the busy/done handshake.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          shift_en,
  output logic          dir,
  output logic          direct_en,
  output logic          busy,
  output logic          done
);

  state_t        state_r;
  logic [CW-1:0] rem_r;
  logic          dir_r;
  logic          busy_r;
  logic          done_r;
  logic          accept_s;

  // Classify this cycle: burst accept, burst shift, or direct mode pass-through.
  always_comb begin
    accept_s  = 1'b0;
    direct_en = 1'b0;
    if (state_r == IDLE) begin
      accept_s  = start && is_shift_mode(mode);
      direct_en = !accept_s;
    end else begin
      accept_s  = 1'b0;
      direct_en = 1'b0;
    end
  end

  assign shift_en = (state_r == SHIFT);
  assign dir      = dir_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // FSM, counter and registered handshake outputs; busy/done track the next state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= IDLE;
      rem_r   <= {CW{1'b0}};
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dir_r <= (mode == MODE_SHL);
            rem_r <= count;
            if (count != {CW{1'b0}}) begin
              state_r <= SHIFT;
              busy_r  <= 1'b1;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          rem_r <= rem_r - CW'(1);
          if (rem_r == CW'(1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register (hold / shift right / shift left / load) with a
// counted burst controller. Define SHREG_ROTATE_EN to let rot select rotate fill bits.
module shift_reg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CW-1:0]    count,
  input  logic             rot,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] next_s;
  logic [1:0]       op_s;
  logic             shift_en_s;
  logic             dir_s;
  logic             direct_en_s;
  logic             rot_s;
  logic             fill_r_s;
  logic             fill_l_s;

`ifdef SHREG_ROTATE_EN
  assign rot_s = rot;
`else
  logic rot_unused_s;
  assign rot_unused_s = rot;
  assign rot_s        = 1'b0;
`endif

  shreg_ctrl #(.CW(CW)) u_ctrl (
    .clock     (clock),
    .clear     (clear),
    .mode      (mode),
    .start     (start),
    .count     (count),
    .shift_en  (shift_en_s),
    .dir       (dir_s),
    .direct_en (direct_en_s),
    .busy      (busy),
    .done      (done)
  );

  assign fill_r_s = rot_s ? out_r[0]       : sin_r;
  assign fill_l_s = rot_s ? out_r[WIDTH-1] : sin_l;

  // Pick the effective operation, then the next register value.
  always_comb begin
    op_s   = MODE_HOLD;
    next_s = out_r;
    if (shift_en_s) begin
      op_s = dir_s ? MODE_SHL : MODE_SHR;
    end else if (direct_en_s) begin
      op_s = mode;
    end else begin
      op_s = MODE_HOLD;
    end
    case (op_s)
      MODE_HOLD: next_s = out_r;
      MODE_SHR:  next_s = {fill_r_s, out_r[WIDTH-1:1]};
      MODE_SHL:  next_s = {out_r[WIDTH-2:0], fill_l_s};
      MODE_LOAD: next_s = pdata;
      default:   next_s = out_r;
    endcase
  end

  // Register datapath.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      out_r <= next_s;
    end
  end

  assign out    = out_r;
  assign sout_r = out_r[0];
  assign sout_l = out_r[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=4) with a behavioural reference model.
module tb_shift_reg_univ;

  logic       clock;
  logic       clear;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] pdata;
  logic       start;
  logic [2:0] count;
  logic       rot;
  logic [3:0] out;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference model: value as an integer, pending shifts, pending done pulse.
  int m_val;
  int m_left;
  int m_dir_left;
  int m_done;

  shift_reg_univ #(.WIDTH(4)) dut (
    .clock(clock), .clear(clear), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata), .start(start), .count(count), .rot(rot), .out(out),
    .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int do_shift(input int v, input int left);
    int fill;
`ifdef SHREG_ROTATE_EN
    if (rot) fill = left ? (v >> 3) & 1 : v & 1;
    else     fill = left ? int'(sin_l) : int'(sin_r);
`else
    fill = left ? int'(sin_l) : int'(sin_r);
`endif
    if (left) return ((v * 2) % 16) + fill;
    return (v / 2) + fill * 8;
  endfunction

  task automatic model_reset();
    m_val = 0; m_left = 0; m_dir_left = 0; m_done = 0;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_val  = do_shift(m_val, m_dir_left);
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1;
    end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
      m_dir_left = (mode == 2'd2);
      if (count == 3'd0) m_done = 1;
      else m_left = int'(count);
    end else begin
      case (mode)
        2'd1: m_val = do_shift(m_val, 0);
        2'd2: m_val = do_shift(m_val, 1);
        2'd3: m_val = int'(pdata);
        default: ;
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mode = 2'd0; start = 1'b0; count = 3'd0; sin_r = 1'b0; sin_l = 1'b0;
    rot = 1'b0; pdata = 4'd0;
  endtask

  task automatic test_reset();
    checks++;
    if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || sout_r !== 1'b0 || sout_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: out=%b busy=%b done=%b sr=%b sl=%b, want 0000/0/0/0/0",
               out, busy, done, sout_r, sout_l);
    end
    clear = 1'b1;
    pdata = 4'b1011; mode = 2'd3;
    step();
    checks++;
    if (out !== 4'b1011) begin errors++; $display("FAIL reset_preload: out=%b want 1011", out); end
    #2 clear = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%b busy=%b done=%b want 0000/0/0", out, busy, done);
    end
    model_reset();
    // Abort a burst mid-flight: no done pulse may follow.
    clear = 1'b1;
    idle_inputs();
    mode = 2'd1; start = 1'b1; count = 3'd4;
    step();
    idle_inputs();
    step();
    #2 clear = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: busy=%b done=%b want 0/0", busy, done);
    end
    model_reset();
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reset_no_done: busy=%b done=%b want 0/0", busy, done);
      end
    end
  endtask

  task automatic test_load_hold();
    idle_inputs();
    pdata = 4'b1011; mode = 2'd3;
    step();
    checks++;
    if (out !== 4'b1011) begin errors++; $display("FAIL load: out=%b want 1011", out); end
    mode = 2'd0; pdata = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out !== 4'b1011) begin errors++; $display("FAIL hold: out=%b want 1011", out); end
    end
  endtask

  task automatic test_shift_right();
    mode = 2'd1; sin_r = 1'b0;
    step();
    checks++;
    if (out !== 4'b0101 || sout_r !== 1'b1 || sout_l !== 1'b0) begin
      errors++; $display("FAIL shr: out=%b sout_r=%b sout_l=%b want 0101/1/0", out, sout_r, sout_l);
    end
  endtask

  task automatic test_burst_left();
    logic [3:0] exp_seq [3];
    int busy_cycles;
    exp_seq[0] = 4'b0011; exp_seq[1] = 4'b0111; exp_seq[2] = 4'b1111;
    idle_inputs();
    pdata = 4'b0001; mode = 2'd3;
    step();
    mode = 2'd2; start = 1'b1; count = 3'd3; sin_l = 1'b1;
    step();
    checks++;
    if (out !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL burst_accept: out=%b busy=%b done=%b want 0001/1/0", out, busy, done);
    end
    busy_cycles = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy) busy_cycles++;
      checks++;
      if (out !== exp_seq[i]) begin
        errors++; $display("FAIL burst_step%0d: out=%b want %b", i, out, exp_seq[i]);
      end
    end
    checks++;
    if (busy_cycles !== 3 || done !== 1'b1) begin
      errors++; $display("FAIL burst_end: busy_cycles=%0d done=%b want 3/1", busy_cycles, done);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 4'b1111) begin
      errors++; $display("FAIL burst_no_rerun: busy=%b done=%b out=%b want 0/0/1111", busy, done, out);
    end
    idle_inputs();
  endtask

  task automatic test_zero_burst();
    idle_inputs();
    pdata = 4'b1001; mode = 2'd3;
    step();
    mode = 2'd1; start = 1'b1; count = 3'd0; sin_r = 1'b1;
    step();
    checks++;
    if (out !== 4'b1001 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL zero_burst: out=%b busy=%b done=%b want 1001/0/1", out, busy, done);
    end
    idle_inputs();
    step();
    checks++;
    if (out !== 4'b1001 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_after: out=%b busy=%b done=%b want 1001/0/0", out, busy, done);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] want;
    int n;
`ifdef SHREG_ROTATE_EN
    want = 4'b0001;
`else
    want = 4'b0000;
`endif
    idle_inputs();
    pdata = 4'b1000; mode = 2'd3;
    step();
    mode = 2'd2; rot = 1'b1; sin_l = 1'b0; start = 1'b1; count = 3'd5;
    step();
    start = 1'b0; mode = 2'd0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (done !== 1'b1 || out !== want) begin
      errors++; $display("FAIL rotate: done=%b out=%b want 1/%b", done, out, want);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mode  = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
      count = 3'($urandom_range(0, 7));
      sin_r = 1'($urandom); sin_l = 1'($urandom); rot = 1'($urandom);
      pdata = 4'($urandom);
      step();
      checks++;
      if (out !== 4'(m_val) || sout_r !== 1'(m_val & 1) || sout_l !== 1'((m_val >> 3) & 1)
          || busy !== (m_left > 0) || done !== (m_done != 0)) begin
        errors++;
        $display("FAIL random%0d: out=%b busy=%b done=%b want %b/%0d/%0d",
                 i, out, busy, done, 4'(m_val), m_left > 0, m_done);
      end
      if ($urandom_range(0, 60) == 0) begin
        #2 clear = 1'b0;
        #1 model_reset();
        checks++;
        if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL random_clear: out=%b busy=%b done=%b", out, busy, done);
        end
        clear = 1'b1;
      end
    end
  endtask

  initial begin
    clear = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    test_reset();
    test_load_hold();
    test_shift_right();
    test_burst_left();
    test_zero_burst();
    test_rotate();
    model_reset();
    m_val = int'(out);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
